alu_seq_ctrl: RTL



---
 rtl/alu_pkg.sv | 77 +++++++
 rtl/alu_core.sv | 31 +++
 rtl/alu_seq_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the RV32 ALU issue controller.
//   - ALU op codes {funct7[5], funct3}
//   - major opcodes OPC_OP / OPC_OP_IMM
//   - controller state encoding
//   - decode helper mapping opcode/funct3/funct7 to an op and legality
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic       illegal;
    logic       is_shift;
    logic [3:0] op;
  } dec_t;

  // OP-IMM carries an immediate in funct7, so only the shift encodings
  // look at it; the arithmetic-shift flag is the only bit that survives.
  function automatic dec_t decode_op(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic [6:0] funct7);
    dec_t d;
    d.op       = {funct7[5], funct3};
    d.illegal  = 1'b0;
    d.is_shift = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          d.illegal = 1'b0;
        end else if ((funct7 == 7'b0100000) &&
                     ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          d.illegal = 1'b0;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d.op = {1'b0, funct3};
        case (funct3)
          3'b001: d.illegal = (funct7 != 7'b0000000);
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              d.op = OP_SRL;
            end else if (funct7 == 7'b0100000) begin
              d.op = OP_SRA;
            end else begin
              d.illegal = 1'b1;
            end
          end
          default: d.illegal = 1'b0;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    d.is_shift = !d.illegal &&
                 ((d.op == OP_SLL) || (d.op == OP_SRL) || (d.op == OP_SRA));
    return d;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath for the single-cycle (non-shift) ops.
// Ports:
//   op  in  4   ALU op code {funct7[5], funct3}
//   a   in  32  first operand
//   b   in  32  second operand
//   y   out 32  result (0 for shift or unknown codes)
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Op select for arithmetic, compare and logic operations.
  always_comb begin
    y = 32'd0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: y = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  y = a ^ b;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issue controller / sequencer for the RV32 integer ALU.
// Decodes OP/OP-IMM fields, executes non-shift ops in one cycle and runs
// shifts through a serial shifter moving SHIFT_STEP bits per cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   instruction + operand handshake
//   opcode/funct3/funct7 decoded instruction fields
//   src_a/src_b         operands (src_b[4:0] is the shift amount)
//   out_valid/out_ready result handshake
//   result/illegal      registered result and illegal-encoding flag
//   busy                high while a shift is being sequenced
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        illegal,
  output logic        busy
);

  localparam logic [5:0] STEP_W = 6'(SHIFT_STEP);

  state_e      state_r, state_nxt_s;
  logic [31:0] shreg_r, shifted_s, core_y_s, result_r;
  logic [5:0]  rem_r, rem_nxt_s, step_s, shamt_s;
  logic [3:0]  sop_r;
  logic        illegal_r, in_ready_s, accept_s, load_shift_s;
  dec_t        dec_s;

  assign dec_s        = decode_op(opcode, funct3, funct7);
  assign shamt_s      = {1'b0, src_b[4:0]};
  assign accept_s     = in_valid && in_ready_s;
  assign load_shift_s = accept_s && dec_s.is_shift && (shamt_s != 6'd0);

  alu_core u_core (
    .op (dec_s.op),
    .a  (src_a),
    .b  (src_b),
    .y  (core_y_s)
  );

  // Serial shifter step: last step may be shorter than SHIFT_STEP.
  always_comb begin
    step_s    = (rem_r < STEP_W) ? rem_r : STEP_W;
    rem_nxt_s = rem_r - step_s;
    shifted_s = shreg_r;
    case (sop_r)
      OP_SLL:  shifted_s = shreg_r << step_s;
      OP_SRL:  shifted_s = shreg_r >> step_s;
      OP_SRA:  shifted_s = $signed(shreg_r) >>> step_s;
      default: shifted_s = shreg_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE with out_ready re-accepts with IDLE semantics.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = load_shift_s ? SHIFT : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (rem_nxt_s == 6'd0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nxt_s = load_shift_s ? SHIFT : DONE;
        end else if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the state register.
  always_comb begin
    in_ready_s = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      SHIFT:   busy       = 1'b1;
      DONE: begin
        out_valid  = 1'b1;
        in_ready_s = out_ready;
      end
      default: in_ready_s = 1'b0;
    endcase
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = in_ready_s;
    end
  end

  assign in_ready = in_ready_s;

  // Operand capture, serial shift sequencing and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r   <= 32'd0;
      rem_r     <= 6'd0;
      sop_r     <= 4'd0;
      result_r  <= 32'd0;
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      if (load_shift_s) begin
        shreg_r   <= src_a;
        rem_r     <= shamt_s;
        sop_r     <= dec_s.op;
        illegal_r <= 1'b0;
      end else begin
        // shamt=0 shifts pass src_a through unchanged.
        result_r  <= dec_s.illegal  ? 32'd0 :
                     dec_s.is_shift ? src_a : core_y_s;
        illegal_r <= dec_s.illegal;
      end
    end else if (state_r == SHIFT) begin
      shreg_r <= shifted_s;
      rem_r   <= rem_nxt_s;
      if (rem_nxt_s == 6'd0) begin
        result_r  <= shifted_s;
        illegal_r <= 1'b0;
      end
    end
  end

  assign result  = result_r;
  assign illegal = illegal_r;

endmodule
